// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-through, EX/MEM and MEM/WB operand
// forwarding, load-use stall detection and bubble insertion on stall/flush.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_alu_op,
    input  logic        id_use_imm,
    input  logic        id_dest_rt,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_wdata,
    output logic        stall,
    output logic [31:0] arg1,
    output logic [31:0] arg2,
    output logic [4:0]  alu_op,
    output logic [4:0]  shamt,
    output logic [31:0] store_data,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_valid
);

    // Register 0 is hardwired, so a write to it never produces a usable value.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] latched,
        input logic        em_we,
        input logic [4:0]  em_rd,
        input logic [31:0] em_val,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_val
    );
        logic [31:0] res;
        if (em_we && (em_rd != 5'd0) && (em_rd == src)) begin
            res = em_val;
        end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src)) begin
            res = mw_val;
        end else begin
            res = latched;
        end
        return res;
    endfunction

    logic        valid_r, reg_write_r, mem_read_r, mem_write_r, use_imm_r;
    logic [4:0]  dest_r, alu_op_r, shamt_r, rs_r, rt_r;
    logic [31:0] rs_val_r, rt_val_r, imm_r;

    logic        stall_s, load_s;
    logic [4:0]  dest_s;
    logic [31:0] rs_wt_s, rt_wt_s, fwd_rs_s, fwd_rt_s;

    // Load-use hazard detection against the instruction currently in EX.
    always_comb begin
        stall_s = 1'b0;
        if (valid_r && mem_read_r && (dest_r != 5'd0) &&
            ((dest_r == id_rs) || (dest_r == id_rt)) && id_valid && !flush) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Capture-side selection: destination and MEM/WB write-through.
    always_comb begin
        load_s  = id_valid & ~flush & ~stall_s;
        dest_s  = id_dest_rt ? id_rt : id_rd;
        rs_wt_s = id_rs_val;
        rt_wt_s = id_rt_val;
        if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rs)) begin
            rs_wt_s = memwb_wdata;
        end else begin
            rs_wt_s = id_rs_val;
        end
        if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rt)) begin
            rt_wt_s = memwb_wdata;
        end else begin
            rt_wt_s = id_rt_val;
        end
    end

    // Pipeline register: loads the decoded instruction or a zeroed bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            use_imm_r   <= 1'b0;
            dest_r      <= 5'd0;
            alu_op_r    <= 5'd0;
            shamt_r     <= 5'd0;
            rs_r        <= 5'd0;
            rt_r        <= 5'd0;
            rs_val_r    <= 32'd0;
            rt_val_r    <= 32'd0;
            imm_r       <= 32'd0;
        end else if (load_s) begin
            valid_r     <= 1'b1;
            reg_write_r <= id_reg_write;
            mem_read_r  <= id_mem_read;
            mem_write_r <= id_mem_write;
            use_imm_r   <= id_use_imm;
            dest_r      <= dest_s;
            alu_op_r    <= id_alu_op;
            shamt_r     <= id_shamt;
            rs_r        <= id_rs;
            rt_r        <= id_rt;
            rs_val_r    <= rs_wt_s;
            rt_val_r    <= rt_wt_s;
            imm_r       <= id_imm;
        end else begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            use_imm_r   <= 1'b0;
            dest_r      <= 5'd0;
            alu_op_r    <= 5'd0;
            shamt_r     <= 5'd0;
            rs_r        <= 5'd0;
            rt_r        <= 5'd0;
            rs_val_r    <= 32'd0;
            rt_val_r    <= 32'd0;
            imm_r       <= 32'd0;
        end
    end

    // Operand forwarding; EX/MEM takes precedence over MEM/WB.
    always_comb begin
        fwd_rs_s = fwd_sel(rs_r, rs_val_r, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_wdata);
        fwd_rt_s = fwd_sel(rt_r, rt_val_r, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_wdata);
    end

    assign stall        = stall_s;
    assign arg1         = fwd_rs_s;
    assign arg2         = use_imm_r ? imm_r : fwd_rt_s;
    assign store_data   = fwd_rt_s;
    assign alu_op       = alu_op_r;
    assign shamt        = shamt_r;
    assign ex_dest      = dest_r;
    assign ex_reg_write = reg_write_r;
    assign ex_mem_read  = mem_read_r;
    assign ex_mem_write = mem_write_r;
    assign ex_valid     = valid_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt, id_alu_op;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic        id_use_imm, id_dest_rt, id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_wdata;
    logic        stall;
    logic [31:0] arg1, arg2, store_data;
    logic [4:0]  alu_op, shamt, ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_use_imm(id_use_imm),
        .id_dest_rt(id_dest_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .stall(stall), .arg1(arg1), .arg2(arg2), .alu_op(alu_op), .shamt(shamt),
        .store_data(store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_rs_val = 32'd0; id_rt_val = 32'd0; id_imm = 32'd0;
        id_shamt = 5'd0; id_alu_op = 5'd0; id_use_imm = 1'b0; id_dest_rt = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; flush = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_wdata = 32'd0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                          input logic use_imm, input logic dest_rt, input logic mem_read);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
        id_use_imm = use_imm; id_dest_rt = dest_rt;
        id_reg_write = 1'b1; id_mem_read = mem_read; id_mem_write = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #3;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_arg1", arg1, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // EX/MEM vs MEM/WB priority
        set_id(5'd3, 5'd4, 5'd7, 32'h55, 32'h66, 32'd0, 1'b0, 1'b0, 1'b0);
        id_alu_op = 5'd1; id_shamt = 5'd3;
        tick();
        chk("cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("cap_dest_rd", {27'd0, ex_dest}, 32'd7);
        chk("cap_aluop", {27'd0, alu_op}, 32'd1);
        chk("cap_shamt", {27'd0, shamt}, 32'd3);
        chk("nofwd_arg1", arg1, 32'h55);
        chk("nofwd_arg2", arg2, 32'h66);
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_wdata = 32'h99;
        #1;
        chk("exmem_wins", arg1, 32'h10);
        chk("store_nofwd", store_data, 32'h66);
        exmem_reg_write = 1'b0;
        #1;
        chk("memwb_fwd", arg1, 32'h99);

        // Write-through at capture
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_wdata = 32'hDEAD_BEEF;
        set_id(5'd1, 5'd5, 5'd9, 32'h11, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0);
        id_alu_op = 5'd2; id_shamt = 5'd0;
        tick();
        memwb_reg_write = 1'b0;
        #1;
        chk("wthru_arg2", arg2, 32'hDEAD_BEEF);
        chk("wthru_arg1", arg1, 32'h11);
        chk("dest_rt", {27'd0, ex_dest}, 32'd5);

        // Register 0: no write-through, no forwarding
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_wdata = 32'hABC;
        set_id(5'd0, 5'd6, 5'd10, 32'h0, 32'h77, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h1234;
        #1;
        chk("r0_arg1", arg1, 32'h0);
        chk("r0_arg2", arg2, 32'h77);
        idle_inputs();

        // Immediate operand, store data still forwarded
        set_id(5'd9, 5'd8, 5'd11, 32'h1, 32'h88, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        id_mem_write = 1'b1; id_shamt = 5'd7;
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h4242;
        #1;
        chk("imm_arg2", arg2, 32'hFFFF_FFFC);
        chk("imm_store", store_data, 32'h4242);
        chk("imm_memw", {31'd0, ex_mem_write}, 32'd1);
        chk("imm_shamt", {27'd0, shamt}, 32'd7);
        idle_inputs();

        // Load-use: lw r2 then add r4,r2,r1
        set_id(5'd1, 5'd2, 5'd0, 32'h100, 32'h0, 32'd4, 1'b1, 1'b1, 1'b1);
        tick();
        chk("lw_memread", {31'd0, ex_mem_read}, 32'd1);
        chk("lw_dest", {27'd0, ex_dest}, 32'd2);
        set_id(5'd2, 5'd1, 5'd4, 32'h0, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0);
        id_alu_op = 5'd0;
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_dest", {27'd0, ex_dest}, 32'd0);
        chk("lu_stall_drop", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_dest", {27'd0, ex_dest}, 32'd4);

        // Flush with simultaneous hazard
        set_id(5'd1, 5'd2, 5'd0, 32'h100, 32'h0, 32'd4, 1'b1, 1'b1, 1'b1);
        tick();
        set_id(5'd2, 5'd1, 5'd4, 32'h0, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("fl_bubble", {31'd0, ex_valid}, 32'd0);
        chk("fl_regw", {31'd0, ex_reg_write}, 32'd0);
        flush = 1'b0;

        // id_valid=0 yields bubble even with populated fields
        set_id(5'd3, 5'd4, 5'd12, 32'h5, 32'h6, 32'd0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
        tick();
        chk("inv_valid", {31'd0, ex_valid}, 32'd0);
        chk("inv_dest", {27'd0, ex_dest}, 32'd0);
        chk("inv_arg1", arg1, 32'h0);

        // Reset asserted mid-stall
        set_id(5'd1, 5'd2, 5'd0, 32'h100, 32'h0, 32'd4, 1'b1, 1'b1, 1'b1);
        tick();
        set_id(5'd2, 5'd1, 5'd4, 32'h0, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mrst_pre_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        chk("mrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mrst_arg2", arg2, 32'd0);
        chk("mrst_store", store_data, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_before", {31'd0, ex_valid}, 32'd0);
        tick();
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_dest", {27'd0, ex_dest}, 32'd4);
        chk("post_rst_arg2", arg2, 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
